// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared CPU definitions used by the fetch stage and the main decoder:
//   - fetch FSM state encoding (IDLE / WAIT / DROP)
//   - default reset PC and instruction buffer depth
//   - the {pc, instr} record stored in the instruction buffer
//   - primary opcode constants (instr[31:26]) consumed by the main decoder
//   - small helpers for word alignment and opcode extraction
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          IBUF_DEPTH       = 2;

    // Fetch FSM encoding; also exported on the debug port of instr_fetch.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // free to issue a read (if the buffer has room)
        S_WAIT = 2'd1,  // one read outstanding, response will be kept
        S_DROP = 2'd2   // one read outstanding, response will be thrown away
    } fetch_state_t;

    // One instruction buffer entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Primary opcodes (instr[31:26]) for the main decoder.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Clear the byte offset of an address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Primary opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// ---------------------------------------------------------------------------
// instr_buf
//   Two-entry FIFO of {pc, instr} records between fetch and decode.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset (clears everything)
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : {pc, instr} record to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop in the same cycle
//   count      : number of valid entries (0..2)
//   head       : head entry, read straight from registered storage
// ---------------------------------------------------------------------------
module instr_buf
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam logic [1:0] FULL_CNT = 2'(IBUF_DEPTH);

    fetch_entry_t mem [IBUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; the freed slot is the one the write pointer points at.
    assign do_push = push && ((cnt_q != FULL_CNT) || pop);
    assign do_pop  = pop && (cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count = cnt_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage: issues single-outstanding reads to instruction
//   memory, buffers up to two fetched words with their PCs, and hands them to
//   decode. A taken branch/jump (redirect) flushes the buffer and restarts
//   fetching at the target; a read already in flight at that moment is
//   discarded when it returns.
//
// Parameters
//   RESET_PC    : first fetch address after reset
//   DEPTH       : instruction buffer depth (fixed at 2)
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   imem_req    : out, one-cycle read request at imem_addr
//   imem_addr   : out, word-aligned fetch address
//   imem_valid  : in,  one-cycle pulse, imem_rdata holds the read data
//   imem_rdata  : in,  instruction word from memory
//   instr_valid : out, buffer head holds an instruction
//   instr_ready : in,  decode accepts the head entry
//   instr_out   : out, head instruction (instr_out[31:26] = opcode)
//   pc_out      : out, address of the head instruction
//   redirect    : in,  branch/jump taken, refetch from redirect_pc
//   redirect_pc : in,  target address, low two bits ignored
//   dbg_state   : out, current fetch FSM state
//
// Decode handshake: an entry moves to decode in every cycle where
// instr_valid and instr_ready are both high at the rising edge. instr_valid
// never depends on instr_ready, and once high it stays high with stable
// instr_out/pc_out until the transfer or a redirect flush.
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = IBUF_DEPTH
)(
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_valid,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr_out,
    output logic [31:0]  pc_out,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output fetch_state_t dbg_state
);

    localparam logic [31:0] START_PC = word_align(RESET_PC);
    localparam logic [1:0]  FULL_CNT = 2'(DEPTH);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  target_pc;

    logic         req;
    logic         push;
    logic         pop;
    logic         flush;
    logic [1:0]   buf_count;
    fetch_entry_t push_data;
    fetch_entry_t head;

    assign target_pc = word_align(redirect_pc);
    assign push_data = '{pc: pc_q, instr: imem_rdata};

    // -----------------------------------------------------------------------
    // FSM + PC: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM + PC: next state, PC update and buffer controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    // Target is loaded now; the read goes out next cycle.
                    flush = 1'b1;
                    pc_d  = target_pc;
                end else if (buf_count != FULL_CNT) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = target_pc;
                    // If the response is here already it is simply not
                    // pushed; otherwise it is still in flight and must be
                    // swallowed when it arrives.
                    state_d = imem_valid ? S_IDLE : S_DROP;
                end else if (imem_valid) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;  // wraps modulo 2^32
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // Buffer is already empty here, so a further redirect only
                // needs to move the PC.
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pop = instr_valid && instr_ready;

    instr_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (buf_count),
        .head      (head)
    );

    // -----------------------------------------------------------------------
    // Outputs. Reset forces the visible values immediately, before the
    // registers have been cleared by the first reset edge.
    // -----------------------------------------------------------------------
    assign imem_req    = req && !rst;
    assign imem_addr   = rst ? START_PC : pc_q;
    assign instr_valid = !rst && (buf_count != 2'd0);
    assign instr_out   = rst ? 32'h0 : head.instr;
    assign pc_out      = rst ? 32'h0 : head.pc;
    assign dbg_state   = state_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-003 Parameter DEPTH, fixed at 2: number of entries in the instruction buffer.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  one-cycle pulse that issues a read at imem_addr.
REQ-007 imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
REQ-008 imem_valid  in  1  one-cycle pulse that marks imem_rdata as valid for the outstanding read.
REQ-009 imem_rdata  in  32  instruction word returned by memory.
REQ-010 instr_valid  out  1  the buffer head holds a valid instruction.
REQ-011 instr_ready  in  1  the decode stage accepts the head entry; a transfer occurs when instr_valid and instr_ready are both high.
REQ-012 instr_out  out  32  head instruction; instr_out[31:26] drives the main decoder's opcode input.
REQ-013 pc_out  out  32  address of the head instruction.
REQ-014 redirect  in  1  branch/jump taken; flush the buffer and refetch from redirect_pc.
REQ-015 redirect_pc  in  32  target address; bits [1:0] are ignored and forced to 0.

Function
REQ-016 The block SHALL keep a 32-bit fetch PC, a DEPTH-entry FIFO of {pc, instr} pairs, a 2-bit count, and a 3-state FSM: IDLE, WAIT, DROP.
REQ-017 In IDLE, when count < 2 and redirect is low, the block SHALL assert imem_req for exactly one cycle with imem_addr = PC, then enter WAIT.
REQ-018 In IDLE, when count == 2 (full), imem_req SHALL stay low and the FSM SHALL stay in IDLE.
REQ-019 At most one memory read SHALL be outstanding at any time; imem_req SHALL never assert outside IDLE.
REQ-020 In WAIT, on imem_valid without redirect, the block SHALL push {PC, imem_rdata}, set PC to PC+4, and return to IDLE.
REQ-021 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-022 In WAIT, on redirect without imem_valid, the block SHALL flush the FIFO, load PC with {redirect_pc[31:2], 2'b00}, and enter DROP.
REQ-023 In WAIT, on redirect in the same cycle as imem_valid, the block SHALL discard the response, flush the FIFO, load the new PC, and enter IDLE.
REQ-024 In DROP, the block SHALL discard the next imem_valid response and then enter IDLE; a redirect while in DROP SHALL only reload PC.
REQ-025 In IDLE, on redirect, the block SHALL flush the FIFO, load the new PC, and issue no request that cycle.
REQ-026 On a simultaneous push and pop, count SHALL stay unchanged and FIFO order SHALL be preserved.
REQ-027 On a simultaneous redirect and pop, the flush SHALL win and count SHALL become 0.
REQ-028 instr_valid SHALL equal (count != 0); instr_out and pc_out SHALL be driven from registered FIFO storage, with no combinational path from imem_rdata.
REQ-029 Minimum latency from imem_valid to instr_valid SHALL be 1 cycle, when the FIFO was empty.

Reset
REQ-030 While rst is high, the block SHALL set PC = RESET_PC, count = 0, FSM = IDLE, imem_req = 0, and instr_valid = 0.
REQ-031 While rst is high, instr_out and pc_out SHALL read 32'h0, and imem_addr SHALL read RESET_PC.
REQ-032 An imem_valid that arrives after a reset asserted mid-WAIT SHALL be ignored; the memory side is reset in the same cycle.
REQ-033 The first imem_req SHALL occur in the first cycle after rst deasserts.

Structure
REQ-034 FSM state encodings and RESET_PC SHALL live in the shared CPU package, alongside the opcode constants the main decoder uses.
REQ-035 The FIFO SHALL be a sub-module named instr_buf, with push, pop, flush, count, and head outputs.
REQ-036 The FSM and PC logic SHALL remain in instr_fetch.

Verification
REQ-037 Bench SHALL cover: reset release, memory latency 1, instr_ready held high -> imem_addr sequence 0, 4, 8, with pc_out matching each instr_out.
REQ-038 Bench SHALL cover: instr_ready low for 10 cycles -> exactly 2 requests issued, count == 2, imem_req low until the first pop.
REQ-039 Bench SHALL cover: redirect to 32'h0000_0103 during WAIT -> the late response is dropped, the next imem_addr is 32'h0000_0100, and the buffer is empty.
REQ-040 Bench SHALL cover: redirect in the same cycle as imem_valid -> the response is discarded, the FSM is in IDLE, and a request to the new PC is issued the next cycle.
REQ-041 Bench SHALL cover: PC = 32'hFFFF_FFFC fetched -> next imem_addr is 32'h0000_0000.
REQ-042 Bench SHALL cover: rst asserted mid-WAIT with a pending imem_valid -> no push occurs, and imem_addr equals RESET_PC after release.
